keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad by driving one column low at a time and sampling the pulled-up row lines.
- Latches a 4-bit key index on each new press.
- Sits directly upstream of the key debouncer: key_down is the raw, possibly bouncy press level that the debouncer consumes to produce its clean level and tick.
- key_code carries the index to the key-decode logic.

---
 rtl/keypad_scanner.sv | 137 +++++++++++++
 tb/tb_keypad_scanner.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad. One column is driven low at a time.
//   The pulled-up rows are synchronized and sampled once per column dwell.
//   The first key found latches a 4-bit index and starts a HOLD phase. HOLD
//   ends after RELEASE_SAMPLES consecutive all-high samples. key_down is the
//   raw press level for the downstream debouncer.
//
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   row_n[3:0] in   keypad rows, active-low, asynchronous to clk
//   col_n[3:0] out  column drive, exactly one bit low
//   key_down   out  1 while a key is held (raw, may bounce)
//   key_code   out  {row, col} of the last detected key
//   code_valid out  one-cycle pulse when key_code is updated
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int CLK_FREQ        = 27_000_000,
  parameter int SCAN_HZ         = 1000,
  parameter int RELEASE_SAMPLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       key_down,
  output logic [3:0] key_code,
  output logic       code_valid
);

  localparam int DWELL = CLK_FREQ / SCAN_HZ;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int REL_W = $clog2(RELEASE_SAMPLES + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_SAMPLES - 1);

  typedef enum logic {
    S_SCAN,
    S_HOLD
  } state_t;

  state_t           r_state;
  logic [3:0]       r_sync1;
  logic [3:0]       r_rs_n;
  logic [CNT_W-1:0] r_cnt;
  logic [REL_W-1:0] r_rel_cnt;
  logic [1:0]       r_col;

  logic             w_sample;
  logic             w_any_low;
  logic [1:0]       w_row;
  logic [1:0]       w_col_next;
  logic [3:0]       w_col_next_n;

  assign w_sample   = (r_cnt == '0);
  assign w_any_low  = ~(&r_rs_n);
  assign w_col_next = r_col + 2'd1;

  // Active-low one-hot decode of the next column index.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col_dec
      assign w_col_next_n[gi] = (w_col_next != 2'(gi));
    end
  endgenerate

  // Lowest-index low row wins when several rows are pulled low together.
  always_comb begin
    w_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r_rs_n[i]) begin
        w_row = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_SCAN;
      r_sync1    <= 4'b1111;
      r_rs_n     <= 4'b1111;
      r_cnt      <= CNT_LOAD;
      r_rel_cnt  <= '0;
      r_col      <= 2'd0;
      col_n      <= 4'b1110;
      key_down   <= 1'b0;
      key_code   <= 4'h0;
      code_valid <= 1'b0;
    end else begin
      r_sync1    <= row_n;
      r_rs_n     <= r_sync1;
      code_valid <= 1'b0;

      // Column changes only ever happen on a sample, so one reload covers both.
      if (w_sample) begin
        r_cnt <= CNT_LOAD;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      if (w_sample) begin
        case (r_state)
          S_SCAN: begin
            if (w_any_low) begin
              key_code   <= {w_row, r_col};
              code_valid <= 1'b1;
              key_down   <= 1'b1;
              r_rel_cnt  <= '0;
              r_state    <= S_HOLD;
            end else begin
              r_col <= w_col_next;
              col_n <= w_col_next_n;
            end
          end
          S_HOLD: begin
            if (w_any_low) begin
              // Any low row restarts the release count; no re-latch.
              r_rel_cnt <= '0;
            end else if (r_rel_cnt == REL_LAST) begin
              key_down  <= 1'b0;
              r_rel_cnt <= '0;
              r_col     <= w_col_next;
              col_n     <= w_col_next_n;
              r_state   <= S_SCAN;
            end else begin
              r_rel_cnt <= r_rel_cnt + REL_W'(1);
            end
          end
          default: r_state <= S_SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  localparam int DWELL = 10;

  logic       clk;
  logic       reset_n;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       key_down;
  logic [3:0] key_code;
  logic       code_valid;

  logic [15:0] pressed;   // keypad model: bit r*4+c closes row r to column c
  logic [3:0]  exp_q[$];  // scoreboard of expected key codes
  int checks;
  int failures;
  int n_valid;

  keypad_scanner #(
    .CLK_FREQ(1000),
    .SCAN_HZ(100),
    .RELEASE_SAMPLES(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .row_n(row_n),
    .col_n(col_n),
    .key_down(key_down),
    .key_code(key_code),
    .code_valid(code_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix model: a row reads low if any closed key on it sits in a driven column.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
      end
    end
  end

  // Scoreboard consumer: every code_valid pulse must match the next expected code.
  always @(negedge clk) begin
    if (reset_n && code_valid === 1'b1) begin
      checks++;
      n_valid++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid key_code=%h expected no pulse", key_code);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (key_code !== e) begin
          failures++;
          $display("FAIL valid_code got=%h exp=%h", key_code, e);
        end else begin
          $display("valid pulse key_code=%h ok", key_code);
        end
      end
    end
  end

  task automatic wait_kd(input logic lvl, input int budget, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (key_down === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    pressed = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (col_n !== 4'b1110 || key_down !== 1'b0 || key_code !== 4'h0 || code_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got col=%b kd=%b code=%h v=%b exp col=1110 kd=0 code=0 v=0",
               col_n, key_down, key_code, code_valid);
    end else $display("reset state ok");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_idle;
    logic [3:0] exp_col;
    for (int p = 1; p <= 100; p++) begin
      @(posedge clk); #1;
      if (p % 5 == 0) begin
        case ((p / DWELL) % 4)
          0: exp_col = 4'b1110;
          1: exp_col = 4'b1101;
          2: exp_col = 4'b1011;
          default: exp_col = 4'b0111;
        endcase
        checks++;
        if (col_n !== exp_col || key_down !== 1'b0) begin
          failures++;
          $display("FAIL idle_scan cycle=%0d got col=%b kd=%b exp col=%b kd=0", p, col_n, key_down, exp_col);
        end else $display("idle cycle=%0d col=%b ok", p, col_n);
      end
    end
  endtask

  task automatic test_press;
    int cyc;
    bit ok;
    exp_q.push_back(4'h9);
    pressed[2*4+1] = 1'b1;
    wait_kd(1'b1, 60, cyc, ok);
    checks++;
    if (!ok || cyc > 4*DWELL + 3) begin
      failures++;
      $display("FAIL press_latency got=%0d cycles ok=%0d exp<=%0d", cyc, ok, 4*DWELL + 3);
    end else $display("press latency=%0d ok", cyc);
    checks++;
    if (code_valid !== 1'b1 || col_n !== 4'b1101) begin
      failures++;
      $display("FAIL press_edge got v=%b col=%b exp v=1 col=1101", code_valid, col_n);
    end else $display("press edge ok");
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if (col_n !== 4'b1101 || key_down !== 1'b1 || n_valid != 1) begin
      failures++;
      $display("FAIL hold_frozen got col=%b kd=%b pulses=%0d exp col=1101 kd=1 pulses=1",
               col_n, key_down, n_valid);
    end else $display("hold frozen ok");
  endtask

  task automatic test_release;
    int cyc;
    bit ok;
    pressed = '0;
    wait_kd(1'b0, 80, cyc, ok);
    // First high sample lands 3..12 edges after release; fall is 30 edges later.
    checks++;
    if (!ok || cyc < 32 || cyc > 43) begin
      failures++;
      $display("FAIL release_time got=%0d cycles ok=%0d exp 32..43", cyc, ok);
    end else $display("release after %0d cycles ok", cyc);
    checks++;
    if (col_n !== 4'b1011 || key_code !== 4'h9) begin
      failures++;
      $display("FAIL release_state got col=%b code=%h exp col=1011 code=9", col_n, key_code);
    end else $display("release state ok");
  endtask

  task automatic test_bounce;
    int cyc;
    bit ok;
    bit dropped;
    exp_q.push_back(4'h9);
    pressed[2*4+1] = 1'b1;
    wait_kd(1'b1, 60, cyc, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bounce_press got kd=%b exp kd=1 within 60 cycles", key_down);
    end else $display("bounce press ok");
    repeat (15) @(posedge clk);
    #1;
    dropped = 1'b0;
    pressed = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (key_down !== 1'b1) dropped = 1'b1;
    end
    pressed[2*4+1] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (key_down !== 1'b1) dropped = 1'b1;
    end
    checks++;
    if (dropped || n_valid != 2) begin
      failures++;
      $display("FAIL bounce_hold got dropped=%0d pulses=%0d exp dropped=0 pulses=2", dropped, n_valid);
    end else $display("bounce tolerated ok");
    pressed = '0;
    wait_kd(1'b0, 80, cyc, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bounce_release got kd=%b exp kd=0 within 80 cycles", key_down);
    end else $display("bounce release ok");
  endtask

  task automatic test_multi_row;
    int cyc;
    bit ok;
    exp_q.push_back(4'h7);
    pressed[1*4+3] = 1'b1;
    pressed[3*4+3] = 1'b1;
    wait_kd(1'b1, 60, cyc, ok);
    checks++;
    if (!ok || col_n !== 4'b0111 || key_code !== 4'h7) begin
      failures++;
      $display("FAIL multi_row got ok=%0d col=%b code=%h exp col=0111 code=7", ok, col_n, key_code);
    end else $display("multi row code=%h ok", key_code);
    repeat (20) @(posedge clk);
  endtask

  task automatic test_reset_hold;
    @(negedge clk);
    checks++;
    if (key_down !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_hold got kd=%b exp kd=1", key_down);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (key_down !== 1'b0 || col_n !== 4'b1110 || key_code !== 4'h0) begin
      failures++;
      $display("FAIL async_reset got kd=%b col=%b code=%h exp kd=0 col=1110 code=0",
               key_down, col_n, key_code);
    end else $display("async reset in hold ok");
    pressed = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (col_n !== 4'b1110) begin
      failures++;
      $display("FAIL restart_col0 got col=%b exp col=1110", col_n);
    end
    @(posedge clk); #1;
    checks++;
    if (col_n !== 4'b1101) begin
      failures++;
      $display("FAIL restart_col1 got col=%b exp col=1101", col_n);
    end else $display("scan restarted ok");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    n_valid  = 0;
    reset_n  = 1'b0;
    pressed  = '0;
    test_reset;
    test_idle;
    test_press;
    test_release;
    test_bounce;
    test_multi_row;
    test_reset_hold;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || n_valid != 3) begin
      failures++;
      $display("FAIL scoreboard_end got pending=%0d pulses=%0d exp pending=0 pulses=3",
               exp_q.size(), n_valid);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
